// File: rtl/alu_op_issuer.sv
// Issue stage in front of the ALU: queues requests and drives one op at a time onto the ALU pins.
// After a command-dependent latency the stage captures the result and holds it until rsp_ready.
module alu_op_issuer #(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [DW-1:0]                req_opa,
    input  logic [DW-1:0]                req_opb,
    input  logic [CW-1:0]                req_cmd,
    input  logic                         req_mode,
    input  logic                         req_cin,
    input  logic [1:0]                   req_inp_valid,
    output logic [DW-1:0]                OPA,
    output logic [DW-1:0]                OPB,
    output logic [CW-1:0]                CMD,
    output logic                         MODE,
    output logic                         CIN,
    output logic                         CE,
    output logic [1:0]                   INP_VALID,
    input  logic [2*DW-1:0]              RES,
    input  logic                         COUT,
    input  logic                         OFLOW,
    input  logic                         ERR,
    input  logic                         E,
    input  logic                         G,
    input  logic                         L,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [2*DW-1:0]              rsp_res,
    output logic [5:0]                   rsp_flags,
    output logic [CW-1:0]                rsp_cmd,
    output logic [$clog2(DEPTH):0]       fifo_count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int MAXL = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    localparam int LW   = $clog2(MAXL + 1);
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    typedef struct packed {
        logic [DW-1:0] opa;
        logic [DW-1:0] opb;
        logic [CW-1:0] cmd;
        logic          mode;
        logic          cin;
        logic [1:0]    iv;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    req_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q, count_d;
    logic            ready_q;

    state_t          state_q;
    logic [LW-1:0]   lat_q;
    logic [DW-1:0]   opa_q, opb_q;
    logic [CW-1:0]   cmd_q;
    logic            mode_q, cin_q, ce_q;
    logic [1:0]      iv_q;
    logic            rsp_valid_q;
    logic [2*DW-1:0] rsp_res_q;
    logic [5:0]      rsp_flags_q;
    logic [CW-1:0]   rsp_cmd_q;

    logic            push, pop, is_mul;
    logic [LW-1:0]   head_lat;
    req_t            head, wr_ent;

    always_comb begin
        wr_ent      = '0;
        wr_ent.opa  = req_opa;
        wr_ent.opb  = req_opb;
        wr_ent.cmd  = req_cmd;
        wr_ent.mode = req_mode;
        wr_ent.cin  = req_cin;
        wr_ent.iv   = req_inp_valid;
    end

    assign push     = req_valid && ready_q;
    assign pop      = (state_q == IDLE) && (count_q != '0);
    assign head     = mem_q[rd_ptr_q];
    assign is_mul   = head.mode && ((head.cmd == CW'(9)) || (head.cmd == CW'(10)));
    assign head_lat = is_mul ? LW'(MUL_LAT) : LW'(ALU_LAT);
    assign count_d  = count_q + CNTW'(push) - CNTW'(pop);

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_ent;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ready_q <= (count_d < FULL);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            ce_q        <= 1'b0;
            iv_q        <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
            rsp_cmd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        opa_q   <= head.opa;
                        opb_q   <= head.opb;
                        cmd_q   <= head.cmd;
                        mode_q  <= head.mode;
                        cin_q   <= head.cin;
                        iv_q    <= head.iv;
                        ce_q    <= 1'b1;
                        lat_q   <= head_lat;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // lat_q counts the edges still to go before the ALU output is valid.
                    if (lat_q == LW'(1)) begin
                        rsp_res_q   <= RES;
                        rsp_flags_q <= {COUT, OFLOW, ERR, E, G, L};
                        rsp_cmd_q   <= cmd_q;
                        rsp_valid_q <= 1'b1;
                        ce_q        <= 1'b0;
                        iv_q        <= 2'b00;
                        state_q     <= HOLD;
                    end else begin
                        lat_q <= lat_q - LW'(1);
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign fifo_count = count_q;
    assign OPA        = opa_q;
    assign OPB        = opb_q;
    assign CMD        = cmd_q;
    assign MODE       = mode_q;
    assign CIN        = cin_q;
    assign CE         = ce_q;
    assign INP_VALID  = iv_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_res    = rsp_res_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_cmd    = rsp_cmd_q;

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Upstream issue stage for ALU_DESIGN.
- Accepts operation requests on a valid/ready interface and buffers them in a small FIFO.
- Drives one operation at a time onto the ALU input pins, waits the ALU's fixed pipeline latency, then captures RES and the flags.
- Returns captured results on a valid/ready response interface with backpressure. This serializes traffic so ALU inputs are always stable and well-formed.

Parameters:
- DW, 8, operand width (ALU DW).
- CW, 4, command width (ALU CW).
- DEPTH, 4, request FIFO entries (power of 2, >=2).
- ALU_LAT, 1, cycles from CE-assert edge to valid ALU outputs, non-multiply commands.
- MUL_LAT, 2, same latency for multiply commands (MODE=1, CMD=9 or 10).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept.
- req_opa  in  DW  operand A.
- req_opb  in  DW  operand B.
- req_cmd  in  CW  command.
- req_mode  in  1  1=arithmetic, 0=logical.
- req_cin  in  1  carry in.
- req_inp_valid  in  2  operand-valid code passed to ALU.
- OPA  out  DW  to ALU.
- OPB  out  DW  to ALU.
- CMD  out  CW  to ALU.
- MODE  out  1  to ALU.
- CIN  out  1  to ALU.
- CE  out  1  to ALU.
- INP_VALID  out  2  to ALU.
- RES  in  2*DW  from ALU.
- COUT  in  1  from ALU.
- OFLOW  in  1  from ALU.
- ERR  in  1  from ALU.
- E  in  1  from ALU.
- G  in  1  from ALU.
- L  in  1  from ALU.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts.
- rsp_res  out  2*DW  captured RES.
- rsp_flags  out  6  {COUT,OFLOW,ERR,E,G,L} captured.
- rsp_cmd  out  CW  echo of issued CMD.
- fifo_count  out  log2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (RST=0, async):
  - FIFO emptied, FSM to IDLE.
  - All outputs 0: CE=0, INP_VALID=00, rsp_valid=0, fifo_count=0.
  - req_ready=1 one cycle after release.
  - An in-flight op is discarded with no response.
- All outputs are registered.
- FIFO:
  - Push on req_valid&&req_ready. req_ready = (count<DEPTH), independent of same-cycle pop; no bypass.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - req_valid while full is ignored; no overwrite.
- FSM IDLE:
  - If FIFO non-empty, pop head and load OPA/OPB/CMD/MODE/CIN/INP_VALID from the entry.
  - Set CE=1, load latency counter with LAT, go to WAIT.
  - LAT=MUL_LAT if MODE=1 and CMD is 9 or 10, else ALU_LAT.
- FSM WAIT:
  - ALU inputs and CE held constant.
  - Counter decrements each cycle.
  - Capture RES and flags into rsp_* on the edge exactly LAT cycles after the edge that set CE.
  - On that same edge: rsp_valid=1, CE=0, INP_VALID=00, go to HOLD.
  - OPA/OPB/CMD keep their last values while CE=0.
- FSM HOLD:
  - rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&&rsp_ready: rsp_valid=0 next edge, return to IDLE.
  - Next issue is no earlier than the edge after IDLE is entered (minimum 1 idle cycle between ops).
- ERR from ALU is passed through in rsp_flags. The issuer does not retry, drop, or alter the op.
- INP_VALID=00 requests are still issued and return whatever the ALU produces.
- FIFO accepts requests in all states; only FIFO fullness throttles req_ready.
- Ordering: responses are strictly in request order, one response per accepted request.

Test Plan:
- Single ADD, ALU_LAT=1, MODE=1, CMD=0, OPA=200, OPB=100, INP_VALID=11, rsp_ready=1 -> CE high exactly 1 cycle; rsp_res=300; rsp_flags COUT=1; rsp_cmd=0; rsp_valid one cycle.
- Multiply latency, MODE=1, CMD=9, OPA=3, OPB=4 -> CE held MUL_LAT=2 cycles; capture 2 edges after CE assert; ALU inputs stable throughout.
- Backpressure: push 5 requests back-to-back with rsp_ready=0 -> first issued; 4 remain buffered (fifo_count=4, req_ready=0); 6th req_valid ignored. Release rsp_ready -> all 5 responses return in order.
- Wrap and simultaneous push/pop: 10 requests with random gaps, held at count=DEPTH-1 -> pointer wrap is correct; push+pop cycle keeps count constant; data integrity on all 10.
- Async reset mid-WAIT: assert RST=0 between clock edges during WAIT -> CE, INP_VALID, rsp_valid go 0 immediately; count=0; no stale response after release.
- ERR passthrough: MODE=1, CMD=0, INP_VALID=01, with the ALU driving ERR=1 for a missing operand -> rsp_flags ERR bit=1; next queued op issues normally.
